chan_mux_seq: RTL and testbench
===============================

// Module: chan_mux_seq
// PURPOSE
//  Registered, parametrised N-channel x W-bit selector, successor to the 8:1 bit mux.
//  Two modes: MANUAL (one sample of d[sel] per load pulse) and SCAN (round-robin over
//  enabled channels, one sample every DWELL cycles). The output is a one-entry
//  valid/ready register. Feeds channel data to downstream display/logging logic.
// PARAMETERS
//  N      8   number of channels, >=2
//  W      8   data width per channel, >=1
//  SELW   $clog2(N)   select/channel-index width (derived, do not override)
//  DWELL  4   cycles per channel in SCAN mode, >=1
// PORTS
//  clk      in   1       single clock, all logic on rising edge
//  rst      in   1       synchronous, active-high reset
//  d        in   N*W     packed channels; channel i = d[i*W +: W]
//  sel      in   SELW    MANUAL channel index, sampled when load=1
//  load     in   1       MANUAL request strobe (ignored in SCAN)
//  mode     in   1       0 = MANUAL, 1 = SCAN
//  en_mask  in   N       SCAN channel enables, bit i = channel i
//  y        out  W       captured sample
//  y_ch     out  SELW    channel index of y
//  y_valid  out  1       y/y_ch hold a sample not yet accepted
//  y_ready  in   1       downstream accept; transfer when y_valid & y_ready
//  err      out  1       one-cycle pulse: load with sel >= N
// BEHAVIOUR
//  Reset: y=0, y_ch=0, y_valid=0, err=0, state=IDLE, ptr=0, dwell_cnt=0.
//   A rst in any state takes effect at the same edge. Any held sample is discarded.
//  Slot free = !y_valid | y_ready. Capture: y<=d[ptr], y_ch<=ptr, y_valid<=1.
//   Capture with y_ready=1 in the same cycle replaces the old sample; y_valid stays 1.
//   y_valid falls only on transfer with no capture.
//  FSM states:
//   IDLE
//    - mode=1 -> SCAN; ptr=first enabled channel searching upward from 0; dwell_cnt=0.
//    - mode=0 & load & sel<N -> MAN_PEND; ptr=sel.
//    - load & sel>=N -> err=1 for one cycle; stay in IDLE.
//   MAN_PEND
//    - If the slot is free: capture and go to IDLE.
//    - Otherwise wait, with no timeout.
//    - A new valid load while pending overwrites ptr (latest wins); still one capture.
//    - mode=1 -> SCAN (pending request dropped).
//    - Latency: load sampled at edge k; with the slot free, capture at edge k+1.
//      Data is d at edge k+1.
//   SCAN
//    - dwell_cnt counts 0..DWELL-1.
//    - At DWELL-1 with the slot free: capture d[ptr]; ptr=next enabled channel after ptr,
//      wrapping N-1 -> 0; dwell_cnt=0.
//    - At DWELL-1 with the slot not free: hold dwell_cnt and ptr (stall). No channel is skipped.
//    - en_mask=0: no capture and ptr holds. A mask change applies at the next ptr advance.
//    - If ptr itself is disabled, it still advances normally.
//    - mode=0 -> IDLE at the next edge; the partial dwell is dropped. y/y_valid are untouched.
//    - load ignored; err is not raised.
//  d is not registered on input; only the captured value is registered. The valid/ready
//  handshake is the sole flow control.
// STRUCTURE
//  Header chan_mux_defs.vh: state codes ST_IDLE/ST_MAN_PEND/ST_SCAN (2-bit localparams).
//  Sub-module rr_next_chan #(N,SELW): combinational; inputs cur, mask.
//   Outputs nxt (first set bit strictly after cur, circular) and any (|mask).
//   Also used with cur=N-1 to find the first enabled channel from 0.
//  Top: FSM, dwell counter, output register, W-bit lane select via indexed part-select.
// TESTING (N=8, W=8, DWELL=4; d lane i = 8'h10+i; clk period 10ns)
//  1. Reset: hold rst 2 cycles mid-SCAN with y_valid=1. Expect y=0, y_ch=0, y_valid=0,
//     err=0 after the edge.
//  2. MANUAL: y_ready=1; load with sel=5 at edge k.
//     Expect y=8'h15, y_ch=5, y_valid=1 after edge k+1, and y_valid=0 after edge k+2.
//  3. SCAN: en_mask=8'b1001_0110, y_ready=1. Captured y_ch sequence 1,2,4,7,1,...
//     Exactly 4 cycles between captures; y=8'h11,8'h12,8'h14,8'h17.
//  4. Backpressure: SCAN, y_ready=0 for 10 cycles. y/y_ch frozen, y_valid=1.
//     On release, the next capture is the following enabled channel (none skipped).
//  5. Error: N=6 instance, load with sel=7. Expect a one-cycle err pulse, no capture,
//     state IDLE. sel=5 then captures normally.
//  6. Edge cases:
//     - en_mask=0 in SCAN: no y_valid for 20 cycles.
//     - Set mask 8'h01: ch0 captured every 4 cycles.
//     - Two loads in MAN_PEND with y_ready=0: single capture of the latest sel.

Source files
------------

// File: rtl/chan_mux_seq_pkg.sv
// Shared definitions for the chan_mux_seq channel selector.
//   state_e   : FSM state codes (IDLE, MAN_PEND, SCAN), 2-bit encoded
//   cnt_width : width helper for counters that must be at least one bit wide
package chan_mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAN_PEND = 2'd1,
    ST_SCAN     = 2'd2
  } state_e;

  // A counter over 'depth' values; a depth of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/chan_mux_seq_rr_next.sv
// rr_next_chan: combinational round-robin channel finder.
//   cur  : current channel index
//   mask : channel enables, bit i = channel i
//   nxt  : first enabled channel strictly after cur, wrapping N-1 -> 0;
//          equals cur when no channel is enabled
//   any  : at least one channel enabled
// With cur = N-1 the search starts at channel 0, which gives the first
// enabled channel counting upward from 0.
module rr_next_chan #(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] cur,
  input  logic [N-1:0]    mask,
  output logic [SELW-1:0] nxt,
  output logic            any
);

  assign any = |mask;

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable written here gets a value before any branch,
    // otherwise a path that skips the assignment infers a latch.
    nxt   = cur;
    found = 1'b0;
    idx   = 0;
    // Offsets 1..N visit every other channel once and finally cur itself,
    // so a mask with only cur set returns cur.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(cur) + k) % N;
      if (!found && mask[idx]) begin
        nxt   = SELW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: registered N-channel x W-bit selector with a one-entry
// valid/ready output register.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   d        : packed channel data, channel i = d[i*W +: W] (not registered)
//   sel      : MANUAL channel index, sampled with load
//   load     : MANUAL request strobe (ignored in SCAN)
//   mode     : 0 = MANUAL, 1 = SCAN
//   en_mask  : SCAN channel enables
//   y        : captured sample
//   y_ch     : channel index of y
//   y_valid  : y/y_ch hold a sample not yet accepted
//   y_ready  : downstream accept; transfer on y_valid & y_ready
//   err      : one-cycle pulse for a MANUAL load with sel >= N
// MANUAL: a load moves IDLE -> MAN_PEND, and the sample of d[sel] is taken
// at the first edge where the output slot is free.
// SCAN: round-robin over enabled channels, one capture every DWELL cycles;
// a full output register stalls the dwell counter instead of skipping.
module chan_mux_seq
  import chan_mux_seq_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  d,
  input  logic [SELW-1:0] sel,
  input  logic            load,
  input  logic            mode,
  input  logic [N-1:0]    en_mask,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_ch,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            err
);

  localparam int             DCW        = cnt_width(DWELL);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DCW-1:0]  dwell_q, dwell_d;
  logic [W-1:0]    y_q;
  logic [SELW-1:0] y_ch_q;
  logic            y_valid_q;
  logic            err_q, err_d;

  logic            capture;
  logic            slot_free;
  logic            sel_ok;
  logic [W-1:0]    lane;
  logic [SELW-1:0] nxt_ch, first_ch;
  logic            any_en, any_first;

  // Next enabled channel after the current pointer (SCAN advance).
  rr_next_chan #(.N(N), .SELW(SELW)) u_rr_adv (
    .cur  (ptr_q),
    .mask (en_mask),
    .nxt  (nxt_ch),
    .any  (any_en)
  );

  // Starting from N-1 the circular search begins at channel 0 (SCAN entry).
  rr_next_chan #(.N(N), .SELW(SELW)) u_rr_first (
    .cur  (SELW'(N - 1)),
    .mask (en_mask),
    .nxt  (first_ch),
    .any  (any_first)
  );

  // The register can take a new sample if empty or being drained this cycle.
  assign slot_free = !y_valid_q || y_ready;
  assign sel_ok    = int'(sel) < N;
  assign lane      = d[int'(ptr_q)*W +: W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    capture = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mode) begin
          state_d = ST_SCAN;
          ptr_d   = any_first ? first_ch : '0;
          dwell_d = '0;
        end else if (load) begin
          if (sel_ok) begin
            state_d = ST_MAN_PEND;
            ptr_d   = sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_MAN_PEND: begin
        if (mode) begin
          state_d = ST_SCAN;
          ptr_d   = any_first ? first_ch : '0;
          dwell_d = '0;
        end else begin
          if (slot_free) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end
          // A load arriving with the capture starts a fresh request; while
          // stalled it simply retargets the pending one (latest wins).
          if (load) begin
            if (sel_ok) begin
              state_d = ST_MAN_PEND;
              ptr_d   = sel;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      ST_SCAN: begin
        if (!mode) begin
          state_d = ST_IDLE;
        end else if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else if (any_en && slot_free) begin
          // A disabled ptr (mask changed mid-dwell) is still sampled once
          // and then left, so new masks take effect at the advance.
          capture = 1'b1;
          ptr_d   = nxt_ch;
          dwell_d = '0;
        end
        // Otherwise hold at DWELL-1: stalled or no channel enabled.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      dwell_q   <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      if (capture) begin
        y_q       <= lane;
        y_ch_q    <= ptr_q;
        y_valid_q <= 1'b1;
      end else if (y_ready) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Scoreboard bench for chan_mux_seq: expected samples are queued by the
// stimulus, and a negedge monitor pops and compares on every transfer.
module tb_chan_mux_seq;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  d;
  logic [SELW-1:0] sel = '0;
  logic            load = 1'b0;
  logic            mode = 1'b0;
  logic [N-1:0]    en_mask = '0;
  logic [W-1:0]    y;
  logic [SELW-1:0] y_ch;
  logic            y_valid;
  logic            y_ready = 1'b0;
  logic            err;

  // Second instance with N=6 for out-of-range select checks.
  logic [6*8-1:0]  d6;
  logic [2:0]      sel6 = '0;
  logic            load6 = 1'b0;
  logic            mode6 = 1'b0;
  logic [5:0]      en6 = '0;
  logic [7:0]      y6;
  logic [2:0]      ych6;
  logic            yv6;
  logic            yr6 = 1'b1;
  logic            err6;

  typedef struct {
    logic [7:0] y;
    logic [2:0] ch;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  chan_mux_seq #(.N(N), .W(W), .DWELL(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .sel     (sel),
    .load    (load),
    .mode    (mode),
    .en_mask (en_mask),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .err     (err)
  );

  chan_mux_seq #(.N(6), .W(8), .DWELL(4)) dut6 (
    .clk     (clk),
    .rst     (rst),
    .d       (d6),
    .sel     (sel6),
    .load    (load6),
    .mode    (mode6),
    .en_mask (en6),
    .y       (y6),
    .y_ch    (ych6),
    .y_valid (yv6),
    .y_ready (yr6),
    .err     (err6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready.
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_xfer: got y=0x%0h ch=%0d, required no transfer", y, y_ch);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_y", y, mon_e.y);
        check("sb_ch", y_ch, mon_e.ch);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] ey, input logic [2:0] ech);
    exp_t e;
    e.y  = ey;
    e.ch = ech;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    check({nm, "_drained"}, sb_q.size(), 0);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    for (int i = 0; i < budget && !y_valid; i++) tick();
    check({nm, "_valid_seen"}, y_valid, 1);
  endtask

  task automatic check_gaps(input string nm, input int n_exp);
    check({nm, "_pops"}, pop_cyc.size(), n_exp);
    for (int i = 1; i < pop_cyc.size(); i++)
      check({nm, "_gap"}, pop_cyc[i] - pop_cyc[i-1], 4);
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < N; i++) d[i*W +: W] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) d6[i*8 +: 8] = 8'h10 + 8'(i);

    // Power-on reset.
    tick();
    tick();
    check("rst_y", y, 0);
    check("rst_ych", y_ch, 0);
    check("rst_valid", y_valid, 0);
    check("rst_err", err, 0);
    check("rst6_err", err6, 0);
    rst = 1'b0;
    tick();

    // MANUAL: load sel=5 at edge k, sample after k+1, drained after k+2.
    y_ready = 1'b1;
    sel     = 3'd5;
    load    = 1'b1;
    push(8'h15, 3'd5);
    tick();
    load = 1'b0;
    check("man_pend_valid", y_valid, 0);
    tick();
    check("man_y", y, 8'h15);
    check("man_ych", y_ch, 5);
    check("man_valid", y_valid, 1);
    tick();
    check("man_drop_valid", y_valid, 0);

    // SCAN over mask 1001_0110: channels 1,2,4,7,1 every 4 cycles.
    en_mask = 8'b1001_0110;
    pop_cyc.delete();
    push(8'h11, 3'd1);
    push(8'h12, 3'd2);
    push(8'h14, 3'd4);
    push(8'h17, 3'd7);
    push(8'h11, 3'd1);
    mode = 1'b1;
    wait_drain("scan", 100);
    mode = 1'b0;
    check_gaps("scan", 5);
    tick();
    tick();
    check("scan_exit_valid", y_valid, 0);

    // Backpressure: first sample (ch1) frozen, then ch2 and ch4 follow.
    y_ready = 1'b0;
    mode    = 1'b1;
    wait_valid("bp", 20);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (y !== 8'h11 || y_ch !== 3'd1 || y_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_frozen", ok, 1);
    push(8'h11, 3'd1);
    push(8'h12, 3'd2);
    push(8'h14, 3'd4);
    y_ready = 1'b1;
    wait_drain("bp", 40);
    mode = 1'b0;
    tick();
    tick();

    // Reset mid-SCAN with a held sample.
    y_ready = 1'b0;
    en_mask = 8'hFF;
    mode    = 1'b1;
    wait_valid("rst_scan", 20);
    rst  = 1'b1;
    mode = 1'b0;
    sb_q.delete();
    tick();
    tick();
    check("rst2_y", y, 0);
    check("rst2_ych", y_ch, 0);
    check("rst2_valid", y_valid, 0);
    check("rst2_err", err, 0);
    rst     = 1'b0;
    y_ready = 1'b1;
    tick();

    // Error on the N=6 instance: sel=7 pulses err, no capture.
    sel6  = 3'd7;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    check("err_pulse", err6, 1);
    check("err_no_cap", yv6, 0);
    tick();
    check("err_clear", err6, 0);
    check("err_no_cap2", yv6, 0);
    sel6  = 3'd5;
    load6 = 1'b1;
    tick();
    load6 = 1'b0;
    check("err_after_pend", err6, 0);
    tick();
    check("err6_y", y6, 8'h15);
    check("err6_ych", ych6, 5);
    check("err6_valid", yv6, 1);

    // SCAN with no channels enabled: nothing captured.
    en_mask = '0;
    mode    = 1'b1;
    ok      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (y_valid) ok = 1'b0;
    end
    check("mask0_no_valid", ok, 1);
    mode = 1'b0;
    tick();

    // Single channel enabled: ch0 every 4 cycles.
    en_mask = 8'h01;
    pop_cyc.delete();
    push(8'h10, 3'd0);
    push(8'h10, 3'd0);
    push(8'h10, 3'd0);
    mode = 1'b1;
    wait_drain("ch0", 40);
    mode = 1'b0;
    check_gaps("ch0", 3);
    tick();
    tick();

    // Two loads while pending behind a full register: only the latest lands.
    y_ready = 1'b0;
    sel     = 3'd2;
    load    = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("mp_first_ch", y_ch, 2);
    sel  = 3'd3;
    load = 1'b1;
    tick();
    sel = 3'd6;
    tick();
    load = 1'b0;
    tick();
    tick();
    check("mp_held_ch", y_ch, 2);
    check("mp_held_valid", y_valid, 1);
    push(8'h12, 3'd2);
    push(8'h16, 3'd6);
    y_ready = 1'b1;
    wait_drain("mp", 20);
    tick();
    check("mp_single", y_valid, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
